decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: stop  in  1  global pause; hold all state.
REQ-004 SHALL have: flush  in  1  redirect from execute; squash the instruction being decoded.
REQ-005 SHALL have: command  in  32  instruction from fetch.
REQ-006 SHALL have: now_pc  in  32  PC of command.
REQ-007 SHALL have: ex_rd  in  5, ex_mem_read  in  1  destination and load flag of the instruction currently in execute.
REQ-008 SHALL have: rs1_addr, rs2_addr  out  5  combinational register-file read addresses (command[19:15], command[24:20]).
REQ-009 SHALL have: stall_req  out  1  combinational load-use hazard; fetch holds while high.
REQ-010 SHALL have registered outputs: d_valid 1, d_pc 32, d_imm 32, d_rd 5, d_rs1 5, d_rs2 5, d_funct3 3, d_alu_op 5, d_alu_src_imm 1, d_reg_write 1, d_mem_read 1, d_mem_write 1, d_branch 1, d_jal 1, d_jalr 1, d_lui 1, d_auipc 1, d_illegal 1.

Function
REQ-011 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (as NOP), SYSTEM (ECALL/EBREAK flagged illegal-free, d_reg_write=0).
REQ-012 SHALL generate d_imm sign-extended per format I/S/B/U/J; R-type imm = 0.
REQ-013 SHALL force d_reg_write=0 when rd = x0.
REQ-014 SHALL set d_illegal=1 and all side-effect flags 0 for any unsupported opcode/funct3/funct7 combination; d_valid stays 1.
REQ-015 Latency: one cycle, command at edge N appears on d_* after edge N+1.
REQ-016 stall_req SHALL be 1 when ex_mem_read=1, ex_rd != 0, and ex_rd equals an rs field actually used by the instruction format.
REQ-017 Priority per edge: flush > stop > stall_req > normal.
REQ-018 flush: load NOP bundle (d_valid=0, all flags 0, d_alu_op=ADD, d_rd=0), regardless of stop.
REQ-019 stop (no flush): all d_* hold; stall_req still evaluated combinationally.
REQ-020 stall_req (no flush/stop): load NOP bundle; d_pc holds previous value.
REQ-021 Normal: load decoded bundle of command, d_pc = now_pc, d_valid=1.
REQ-022 Fetch's injected addi x0,x0,0 (0x00000013) SHALL decode to d_valid=1, d_reg_write=0.

Reset
REQ-023 On rst_n low, all d_* SHALL clear to 0 immediately (d_alu_op=ADD encoding 0); released synchronously to clk.
REQ-024 Reset mid-stall SHALL drop the held bundle; first post-reset edge decodes command normally.

Configuration
REQ-025 Macro DECODE_RV32M_EN: when defined, OP with funct7=0000001 SHALL decode to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU alu ops; when undefined, those encodings SHALL set d_illegal=1.

Structure
REQ-026 Shared package SHALL hold opcode constants, alu_op enum (5-bit: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, M-ops), NOP constant 0x00000013.
REQ-027 One sub-module imm_gen (combinational immediate generator) SHALL be instantiated; the pipeline register lives in decode.

Verification
REQ-028 command=0x00500093 (addi x1,x0,5), now_pc=0x80000000 -> next edge d_valid=1, d_rd=1, d_imm=5, d_alu_op=ADD, d_alu_src_imm=1, d_reg_write=1, d_pc=0x80000000.
REQ-029 command=0xFE000EE3 (beq x0,x0,-4) -> d_branch=1, d_imm=0xFFFFFFFC, d_reg_write=0.
REQ-030 ex_mem_read=1, ex_rd=2, command=0x002081B3 (add x3,x1,x2) -> stall_req=1 same cycle; next edge d_valid=0; ex_rd=0 -> stall_req=0.
REQ-031 flush=1 and stop=1 same edge with valid command -> d_valid=0 after edge.
REQ-032 command=0x022081B3 (mul) -> d_alu_op=MUL with DECODE_RV32M_EN, d_illegal=1 without.
REQ-033 rst_n low mid-stream with d_valid=1 -> d_* all 0 without a clock edge.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, ALU op encoding and decoded bundle shared by the decode stage
package decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    // M-ops sit at 5'b10_xxx so the low bits are simply funct3
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        lui;
        logic        auipc;
        logic        illegal;
    } bundle_t;

    localparam bundle_t NOP_BUNDLE = '0;

    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational sign-extended immediate for I/S/B/U/J formats
import decode_pkg::*;

module imm_gen (
    input  logic [31:0] command,
    output logic [31:0] imm
);

    always_comb begin
        case (command[6:0])
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:
                imm = {{20{command[31]}}, command[31:20]};
            OPC_STORE:
                imm = {{20{command[31]}}, command[31:25], command[11:7]};
            OPC_BRANCH:
                imm = {{19{command[31]}}, command[31], command[7], command[30:25], command[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {command[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{command[31]}}, command[31], command[19:12], command[20], command[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - RV32I decode stage with load-use stall; DECODE_RV32M_EN adds the M extension ops
import decode_pkg::*;

module decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stop,
    input  logic        flush,
    input  logic [31:0] command,
    input  logic [31:0] now_pc,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic        stall_req,
    output logic        d_valid,
    output logic [31:0] d_pc,
    output logic [31:0] d_imm,
    output logic [4:0]  d_rd,
    output logic [4:0]  d_rs1,
    output logic [4:0]  d_rs2,
    output logic [2:0]  d_funct3,
    output logic [4:0]  d_alu_op,
    output logic        d_alu_src_imm,
    output logic        d_reg_write,
    output logic        d_mem_read,
    output logic        d_mem_write,
    output logic        d_branch,
    output logic        d_jal,
    output logic        d_jalr,
    output logic        d_lui,
    output logic        d_auipc,
    output logic        d_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        legal;
    logic        use_rs1;
    logic        use_rs2;
    bundle_t     dec;
    bundle_t     q;
    logic [31:0] pc_q;

    assign opcode   = command[6:0];
    assign rd       = command[11:7];
    assign funct3   = command[14:12];
    assign funct7   = command[31:25];
    assign rs1_addr = command[19:15];
    assign rs2_addr = command[24:20];

    imm_gen u_imm_gen (
        .command (command),
        .imm     (imm)
    );

    // Hazard check is by format, so a garbage rs field in U/J types never stalls
    assign use_rs1 = opcode inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
    assign use_rs2 = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    assign stall_req = ex_mem_read && (ex_rd != 5'd0) &&
                       ((use_rs1 && ex_rd == rs1_addr) || (use_rs2 && ex_rd == rs2_addr));

    always_comb begin
        dec       = NOP_BUNDLE;
        dec.valid = 1'b1;
        legal     = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec.rd = rd; dec.imm = imm; dec.alu_op = ALU_PASSB;
                dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; dec.lui = 1'b1;
            end
            OPC_AUIPC: begin
                dec.rd = rd; dec.imm = imm;
                dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; dec.auipc = 1'b1;
            end
            OPC_JAL: begin
                dec.rd = rd; dec.imm = imm; dec.reg_write = 1'b1; dec.jal = 1'b1;
            end
            OPC_JALR: begin
                legal = (funct3 == 3'b000);
                dec.rd = rd; dec.rs1 = rs1_addr; dec.funct3 = funct3; dec.imm = imm;
                dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; dec.jalr = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (funct3[2:1] != 2'b01);
                dec.rs1 = rs1_addr; dec.rs2 = rs2_addr; dec.funct3 = funct3; dec.imm = imm;
                dec.branch = 1'b1;
                dec.alu_op = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            end
            OPC_LOAD: begin
                legal = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
                dec.rd = rd; dec.rs1 = rs1_addr; dec.funct3 = funct3; dec.imm = imm;
                dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
            end
            OPC_STORE: begin
                legal = !funct3[2] && (funct3 != 3'b011);
                dec.rs1 = rs1_addr; dec.rs2 = rs2_addr; dec.funct3 = funct3; dec.imm = imm;
                dec.alu_src_imm = 1'b1; dec.mem_write = 1'b1;
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                dec.rd = rd; dec.rs1 = rs1_addr; dec.funct3 = funct3; dec.imm = imm;
                dec.alu_src_imm = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op = alu_from_funct3(funct3, funct3 == 3'b101 && funct7[5]);
            end
            OPC_OP: begin
                dec.rd = rd; dec.rs1 = rs1_addr; dec.rs2 = rs2_addr; dec.funct3 = funct3;
                dec.reg_write = 1'b1;
                if (funct7 == 7'b0000000)
                    dec.alu_op = alu_from_funct3(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                    dec.alu_op = alu_from_funct3(funct3, 1'b1);
                else if (funct7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
                    dec.alu_op = alu_op_e'({2'b10, funct3});
`else
                    legal = 1'b0;
`endif
                end
                else
                    legal = 1'b0;
            end
            OPC_MISC_MEM: ;
            // Only ECALL/EBREAK are accepted; CSR forms are not supported
            OPC_SYSTEM: legal = (command[31:21] == 11'd0) && (command[19:7] == 13'd0);
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = NOP_BUNDLE;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end
        if (dec.rd == 5'd0)
            dec.reg_write = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= NOP_BUNDLE;
            pc_q <= '0;
        end else if (flush) begin
            q <= NOP_BUNDLE;
        end else if (!stop) begin
            if (stall_req) begin
                q <= NOP_BUNDLE;
            end else begin
                q    <= dec;
                pc_q <= now_pc;
            end
        end
    end

    assign d_valid       = q.valid;
    assign d_pc          = pc_q;
    assign d_imm         = q.imm;
    assign d_rd          = q.rd;
    assign d_rs1         = q.rs1;
    assign d_rs2         = q.rs2;
    assign d_funct3      = q.funct3;
    assign d_alu_op      = q.alu_op;
    assign d_alu_src_imm = q.alu_src_imm;
    assign d_reg_write   = q.reg_write;
    assign d_mem_read    = q.mem_read;
    assign d_mem_write   = q.mem_write;
    assign d_branch      = q.branch;
    assign d_jal         = q.jal;
    assign d_jalr        = q.jalr;
    assign d_lui         = q.lui;
    assign d_auipc       = q.auipc;
    assign d_illegal     = q.illegal;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - directed and randomized bench for decode against a mnemonic-level model
import decode_pkg::*;

module tb_decode;

    logic        clk, rst_n, stop, flush, ex_mem_read, stall_req;
    logic [31:0] command, now_pc, d_pc, d_imm;
    logic [4:0]  ex_rd, rs1_addr, rs2_addr, d_rd, d_rs1, d_rs2, d_alu_op;
    logic [2:0]  d_funct3;
    logic        d_valid, d_alu_src_imm, d_reg_write, d_mem_read, d_mem_write;
    logic        d_branch, d_jal, d_jalr, d_lui, d_auipc, d_illegal;

    decode dut (
        .clk(clk), .rst_n(rst_n), .stop(stop), .flush(flush),
        .command(command), .now_pc(now_pc), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .stall_req(stall_req),
        .d_valid(d_valid), .d_pc(d_pc), .d_imm(d_imm), .d_rd(d_rd), .d_rs1(d_rs1),
        .d_rs2(d_rs2), .d_funct3(d_funct3), .d_alu_op(d_alu_op),
        .d_alu_src_imm(d_alu_src_imm), .d_reg_write(d_reg_write),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_branch(d_branch),
        .d_jal(d_jal), .d_jalr(d_jalr), .d_lui(d_lui), .d_auipc(d_auipc),
        .d_illegal(d_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [9:0] F_SRC = 10'h200, F_RW = 10'h100, F_MR = 10'h080, F_MW = 10'h040,
                           F_BR = 10'h020, F_JAL = 10'h010, F_JALR = 10'h008,
                           F_LUI = 10'h004, F_AUI = 10'h002, F_ILL = 10'h001;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2, op;
        logic [2:0]  f3;
        logic [9:0]  flags;
    } exp_t;

    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] imm_of(input logic [7:0] fmt, input logic [31:0] c);
        int v;
        case (fmt)
            "I": v = int'($signed(c) >>> 20);
            "S": v = (int'($signed(c) >>> 20) & 32'hFFFFFFE0) | int'(c[11:7]);
            "B": v = (c[31] ? -4096 : 0) + int'(c[7]) * 2048 + int'(c[30:25]) * 32 + int'(c[11:8]) * 2;
            "U": v = int'(c & 32'hFFFFF000);
            "J": v = (c[31] ? -(1 << 20) : 0) + int'(c[19:12]) * 4096 + int'(c[20]) * 2048 + int'(c[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] c, input logic [31:0] pc);
        exp_t e;
        logic legal = 1'b1, rd_u = 1'b0, rs1_u = 1'b0, rs2_u = 1'b0, f3_u = 1'b0;
        logic [7:0] fmt = "R";
        int f3 = int'(c[14:12]);
        logic [6:0] f7 = c[31:25];
        logic [4:0] base [8];
        logic [4:0] mops [8];
        base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        mops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        e = '0; e.valid = 1'b1; e.pc = pc; e.op = ALU_ADD;
        case (c[6:0])
            OPC_LUI:   begin fmt = "U"; rd_u = 1; e.op = ALU_PASSB; e.flags = F_SRC | F_RW | F_LUI; end
            OPC_AUIPC: begin fmt = "U"; rd_u = 1; e.flags = F_SRC | F_RW | F_AUI; end
            OPC_JAL:   begin fmt = "J"; rd_u = 1; e.flags = F_RW | F_JAL; end
            OPC_JALR:  begin fmt = "I"; rd_u = 1; rs1_u = 1; f3_u = 1; legal = (f3 == 0);
                             e.flags = F_SRC | F_RW | F_JALR; end
            OPC_BRANCH: begin fmt = "B"; rs1_u = 1; rs2_u = 1; f3_u = 1; legal = !(f3 inside {2, 3});
                             e.flags = F_BR;
                             e.op = (f3 < 4) ? ALU_SUB : (f3 < 6) ? ALU_SLT : ALU_SLTU; end
            OPC_LOAD:  begin fmt = "I"; rd_u = 1; rs1_u = 1; f3_u = 1; legal = (f3 inside {0, 1, 2, 4, 5});
                             e.flags = F_SRC | F_RW | F_MR; end
            OPC_STORE: begin fmt = "S"; rs1_u = 1; rs2_u = 1; f3_u = 1; legal = (f3 inside {0, 1, 2});
                             e.flags = F_SRC | F_MW; end
            OPC_OP_IMM: begin fmt = "I"; rd_u = 1; rs1_u = 1; f3_u = 1; e.flags = F_SRC | F_RW;
                             e.op = base[f3];
                             if (f3 == 1) legal = (f7 == 0);
                             if (f3 == 5) begin
                                 legal = (f7 == 0) || (f7 == 7'h20);
                                 if (f7 == 7'h20) e.op = ALU_SRA;
                             end
                         end
            OPC_OP:    begin rd_u = 1; rs1_u = 1; rs2_u = 1; f3_u = 1; e.flags = F_RW;
                             if (f7 == 0) e.op = base[f3];
                             else if (f7 == 7'h20 && f3 == 0) e.op = ALU_SUB;
                             else if (f7 == 7'h20 && f3 == 5) e.op = ALU_SRA;
`ifdef DECODE_RV32M_EN
                             else if (f7 == 7'h01) e.op = mops[f3];
`endif
                             else legal = 1'b0;
                         end
            OPC_MISC_MEM: ;
            OPC_SYSTEM: legal = (c == 32'h00000073) || (c == 32'h00100073);
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e = '0; e.valid = 1'b1; e.pc = pc; e.flags = F_ILL;
            return e;
        end
        e.rd  = rd_u  ? c[11:7]  : 5'd0;
        e.rs1 = rs1_u ? c[19:15] : 5'd0;
        e.rs2 = rs2_u ? c[24:20] : 5'd0;
        e.f3  = f3_u  ? c[14:12] : 3'd0;
        e.imm = imm_of(fmt, c);
        if (e.rd == 0) e.flags = e.flags & ~F_RW;
        return e;
    endfunction

    function automatic logic ref_stall(input logic [31:0] c, input logic [4:0] xrd, input logic xmr);
        logic r1 = c[6:0] inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
        logic r2 = c[6:0] inside {OPC_BRANCH, OPC_STORE, OPC_OP};
        return xmr && xrd != 0 && ((r1 && xrd == c[19:15]) || (r2 && xrd == c[24:20]));
    endfunction

    function automatic exp_t squashed(input logic [31:0] pc);
        exp_t e = '0;
        e.pc = pc;
        return e;
    endfunction

    task automatic check_outputs();
        check("d_valid",  32'(d_valid),  32'(cur.valid));
        check("d_pc",     d_pc,          cur.pc);
        check("d_imm",    d_imm,         cur.imm);
        check("d_rd",     32'(d_rd),     32'(cur.rd));
        check("d_rs1",    32'(d_rs1),    32'(cur.rs1));
        check("d_rs2",    32'(d_rs2),    32'(cur.rs2));
        check("d_funct3", 32'(d_funct3), 32'(cur.f3));
        check("d_alu_op", 32'(d_alu_op), 32'(cur.op));
        check("d_flags",  32'({d_alu_src_imm, d_reg_write, d_mem_read, d_mem_write, d_branch,
                               d_jal, d_jalr, d_lui, d_auipc, d_illegal}), 32'(cur.flags));
    endtask

    task automatic step(input logic [31:0] c, input logic [31:0] pc, input logic fl,
                        input logic st, input logic [4:0] xrd, input logic xmr);
        logic es;
        @(negedge clk);
        command = c; now_pc = pc; flush = fl; stop = st; ex_rd = xrd; ex_mem_read = xmr;
        #1;
        es = ref_stall(c, xrd, xmr);
        check("stall_req", 32'(stall_req), 32'(es));
        check("rs1_addr",  32'(rs1_addr),  32'(c[19:15]));
        check("rs2_addr",  32'(rs2_addr),  32'(c[24:20]));
        @(posedge clk);
        if (fl)        cur = squashed(cur.pc);
        else if (!st)  cur = es ? squashed(cur.pc) : ref_decode(c, pc);
        #1;
        check_outputs();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        cur = '0;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [6:0] opcs [13];
        logic [31:0] c = $urandom;
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                 OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM, 7'b1111111, 7'b0000000};
        c[6:0] = opcs[$urandom_range(12)];
        if ($urandom_range(1) == 1) begin
            c[11:7]  = 5'($urandom_range(3));
            c[19:15] = 5'($urandom_range(3));
            c[24:20] = 5'($urandom_range(3));
        end
        case ($urandom_range(3))
            0: c[31:25] = 7'h00;
            1: c[31:25] = 7'h20;
            2: c[31:25] = 7'h01;
            default: ;
        endcase
        return c;
    endfunction

    initial begin
        rst_n = 1'b0; stop = 1'b0; flush = 1'b0; command = NOP_INSN; now_pc = '0;
        ex_rd = '0; ex_mem_read = 1'b0;
        cur = '0;
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        step(32'h00500093, 32'h80000000, 0, 0, 0, 0);
        check("addi_imm", d_imm, 32'd5);
        check("addi_wr",  32'({d_valid, d_reg_write, d_alu_src_imm}), 32'h7);
        check("addi_pc",  d_pc, 32'h80000000);

        step(32'hFE000EE3, 32'h80000004, 0, 0, 0, 0);
        check("beq_imm", d_imm, 32'hFFFFFFFC);
        check("beq_flags", 32'({d_branch, d_reg_write}), 32'h2);

        step(32'h00000013, 32'h80000008, 0, 0, 0, 0);
        check("nop_inj", 32'({d_valid, d_reg_write, d_illegal}), 32'h4);

        step(32'h002081B3, 32'h8000000C, 0, 0, 5'd2, 1);
        check("hazard_valid", 32'(d_valid), 32'd0);
        check("hazard_pc", d_pc, 32'h80000008);
        step(32'h002081B3, 32'h8000000C, 0, 0, 5'd0, 1);

        step(32'h00500093, 32'h80000010, 1, 1, 0, 0);
        check("flush_over_stop", 32'(d_valid), 32'd0);

        step(32'h022081B3, 32'h80000014, 0, 0, 0, 0);
`ifdef DECODE_RV32M_EN
        check("mul_op", 32'({d_alu_op, d_illegal}), 32'({ALU_MUL, 1'b0}));
`else
        check("mul_illegal", 32'({d_valid, d_illegal}), 32'h3);
`endif
        step(32'h00000073, 32'h80000018, 0, 0, 0, 0);
        step(32'h00100073, 32'h8000001C, 0, 0, 0, 0);
        step(32'h12345037, 32'h80000020, 0, 1, 0, 0);

        step(32'h00500093, 32'h80000024, 0, 0, 0, 0);
        pulse_reset();
        step(32'h00500093, 32'h80000028, 0, 0, 0, 0);
        step(32'h002081B3, 32'h8000002C, 0, 0, 5'd1, 1);
        pulse_reset();
        step(32'h002081B3, 32'h8000002C, 0, 0, 5'd1, 0);
        check("post_rst_valid", 32'(d_valid), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            step(rand_cmd(), $urandom & 32'hFFFFFFFC,
                 $urandom_range(11) == 0, $urandom_range(7) == 0,
                 5'($urandom_range(3)), $urandom_range(1) == 1);
            if (i % 700 == 350) pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
